// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the crop/normalize pipeline stages.
package pipeline_pkg;

   typedef logic [7:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ap_state_e;

   function automatic int burst_bytes(input int in_w);
      return in_w / 8;
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row counter, advanced once per emitted pixel.
// o_wrap flags an advance at the end of a row; o_last_pixel marks the final pixel of the frame.
module raster_counter
   import pipeline_pkg::*;
#(
   parameter int ROWS = 20,
   parameter int COLS = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_clear,
   input  logic                    i_advance,
   output logic [$clog2(COLS)-1:0] o_cnt_col,
   output logic [$clog2(ROWS)-1:0] o_cnt_row,
   output logic                    o_last_pixel,
   output logic                    o_wrap
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             w_col_last;
   logic             w_row_last;

   assign w_col_last   = (r_col == COL_LAST);
   assign w_row_last   = (r_row == ROW_LAST);
   assign o_last_pixel = w_col_last & w_row_last;
   assign o_wrap       = i_advance & w_col_last;
   assign o_cnt_col    = r_col;
   assign o_cnt_row    = r_row;

   // Column/row position; both wrap at dimension-1 so the widths never overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_clear) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_advance) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : (r_row + ROW_ONE);
         end else begin
            r_col <= r_col + COL_ONE;
         end
      end else begin
         r_col <= r_col;
         r_row <= r_row;
      end
   end

endmodule

// File: rtl/burst_sequentializer.sv
// Unpacks multi-pixel Mono8 bursts into a one-pixel-per-cycle AXI-Stream with raster counters.
// One frame is processed per accepted ap_start.
module burst_sequentializer
   import pipeline_pkg::*;
#(
   parameter  int IN_ROWS          = 20,
   parameter  int IN_COLS          = 20,
   parameter  int PIXELS_PER_BURST = 4,
   localparam int IN_W             = 8 * PIXELS_PER_BURST
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ap_start,
   output logic                       ap_ready,
   output logic                       ap_done,
   output logic                       ap_idle,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic [IN_W-1:0]            s_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output pixel_t                     m_axis_tdata,
   output logic [$clog2(IN_COLS)-1:0] cnt_col,
   output logic [$clog2(IN_ROWS)-1:0] cnt_row
);

   localparam int BURSTS_PER_ROW = IN_COLS / PIXELS_PER_BURST;
   localparam int TOTAL_BURSTS   = IN_ROWS * BURSTS_PER_ROW;
   localparam int TAKEN_W        = $clog2(TOTAL_BURSTS + 1);
   localparam int IDX_W          = (PIXELS_PER_BURST > 1) ? $clog2(PIXELS_PER_BURST) : 1;
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(PIXELS_PER_BURST - 1);
   localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
   localparam logic [TAKEN_W-1:0] TAKEN_MAX = TAKEN_W'(TOTAL_BURSTS);
   localparam logic [TAKEN_W-1:0] TAKEN_ONE = TAKEN_W'(1);

   if ((IN_COLS % PIXELS_PER_BURST) != 0) begin : g_cols_check
      $error("IN_COLS must be a multiple of PIXELS_PER_BURST");
   end
   if (burst_bytes(IN_W) != PIXELS_PER_BURST) begin : g_width_check
      $error("burst width does not match PIXELS_PER_BURST");
   end

   ap_state_e        r_state;
   ap_state_e        w_state_next;
   logic [IN_W-1:0]  r_buf;
   logic             r_buf_valid;
   logic [IDX_W-1:0] r_idx;
   logic [TAKEN_W-1:0] r_taken;
   logic             r_ap_ready;
   logic             r_ap_done;
   logic             r_ap_idle;
   logic             w_s_ready;
   logic             w_load;
   logic             w_pix_hs;
   logic             w_last_pixel;
   logic             w_wrap;
   logic             w_frame_end;

   // Reload is allowed in the same cycle the last buffered pixel leaves, giving gap-free output.
   assign w_s_ready   = (r_state == RUN)
                      && (!r_buf_valid || ((r_idx == IDX_LAST) && m_axis_tready))
                      && (r_taken < TAKEN_MAX);
   assign w_load      = s_axis_tvalid & w_s_ready;
   assign w_pix_hs    = r_buf_valid & m_axis_tready;
   assign w_frame_end = w_wrap & w_last_pixel;

   assign s_axis_tready = w_s_ready;
   assign m_axis_tvalid = r_buf_valid;
   assign m_axis_tdata  = r_buf[7:0];
   assign ap_ready      = r_ap_ready;
   assign ap_done       = r_ap_done;
   assign ap_idle       = r_ap_idle;

   raster_counter #(
      .ROWS (IN_ROWS),
      .COLS (IN_COLS)
   ) u_raster_counter (
      .clk          (clk),
      .reset        (reset),
      .i_clear      (r_state == IDLE),
      .i_advance    (w_pix_hs),
      .o_cnt_col    (cnt_col),
      .o_cnt_row    (cnt_row),
      .o_last_pixel (w_last_pixel),
      .o_wrap       (w_wrap)
   );

   // Frame control next-state.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (ap_start) w_state_next = RUN;
            else          w_state_next = IDLE;
         end
         RUN: begin
            if (w_frame_end) w_state_next = DONE;
            else             w_state_next = RUN;
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // State register and ap_* handshake outputs, registered off the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_ap_ready <= 1'b0;
         r_ap_done  <= 1'b0;
         r_ap_idle  <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_ap_ready <= (r_state == IDLE) && ap_start;
         r_ap_done  <= (w_state_next == DONE);
         r_ap_idle  <= (w_state_next == IDLE);
      end
   end

   // Burst buffer: the current pixel always sits in the low byte, shifted out per handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_buf       <= '0;
         r_buf_valid <= 1'b0;
         r_idx       <= '0;
      end else if (w_load) begin
         r_buf       <= s_axis_tdata;
         r_buf_valid <= 1'b1;
         r_idx       <= '0;
      end else if (w_pix_hs) begin
         r_buf <= r_buf >> 4'd8;
         if (r_idx == IDX_LAST) begin
            r_buf_valid <= 1'b0;
            r_idx       <= '0;
         end else begin
            r_buf_valid <= 1'b1;
            r_idx       <= r_idx + IDX_ONE;
         end
      end else begin
         r_buf       <= r_buf;
         r_buf_valid <= r_buf_valid;
         r_idx       <= r_idx;
      end
   end

   // Bursts accepted this frame; caps input at one frame's worth.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_taken <= '0;
      end else if (r_state != RUN) begin
         r_taken <= '0;
      end else if (w_load) begin
         r_taken <= r_taken + TAKEN_ONE;
      end else begin
         r_taken <= r_taken;
      end
   end

endmodule

// File: doc/burst_sequentializer.md
Name: burst_sequentializer

Overview:
- Upstream stage of the crop/normalize pipeline.
- Accepts a multi-pixel Mono8 burst stream from the frame grabber and emits one pixel per cycle, in raster order, on an AXI-Stream master.
- Drives registered column/row counters aligned to every emitted pixel; downstream croppers use these to decide which pixels to keep.
- Runs one frame per ap_start and reports ap_idle to downstream stages.

Parameters:
- IN_ROWS, 20: frame height in pixels.
- IN_COLS, 20: frame width in pixels. Must be a multiple of PIXELS_PER_BURST; elaboration fails otherwise.
- PIXELS_PER_BURST, 4: Mono8 pixels per input word.
- Derived localparams: BURSTS_PER_ROW = IN_COLS/PIXELS_PER_BURST; IN_W = 8*PIXELS_PER_BURST.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low reset. 0 resets the block.
- ap_start  in  1  request to process one frame.
- ap_ready  out  1  one-cycle pulse when ap_start is accepted.
- ap_done  out  1  one-cycle pulse after the last pixel of the frame is handshaken.
- ap_idle  out  1  high while no frame is in progress.
- s_axis_tvalid  in  1  input burst valid.
- s_axis_tready  out  1  input burst ready.
- s_axis_tdata  in  IN_W  burst data. Byte 0 (bits 7:0) is the leftmost pixel.
- m_axis_tvalid  out  1  pixel valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  8  pixel value.
- cnt_col  out  $clog2(IN_COLS)  column of the pixel currently on m_axis_tdata.
- cnt_row  out  $clog2(IN_ROWS)  row of the pixel currently on m_axis_tdata.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE. Outputs take these values: ap_idle=1, ap_ready=0, ap_done=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, cnt_col=0, cnt_row=0. The burst buffer is invalidated.
- Reset mid-frame: the partial frame is discarded with no ap_done. After release the block waits for a new ap_start.
- State machine has three states, IDLE, RUN and DONE:
  - IDLE, ap_start=1 -> RUN. ap_ready pulses for one cycle. ap_idle falls the same cycle the state enters RUN.
  - RUN: unpacks bursts into pixels.
    - The buffer holds one burst plus a pixel index 0..PIXELS_PER_BURST-1.
    - m_axis_tvalid=1 whenever the buffer is valid.
    - m_axis_tdata = buffer byte[index].
  - On a pixel handshake (m_axis_tvalid && m_axis_tready):
    - index increments.
    - cnt_col increments; at IN_COLS-1 it wraps to 0 and cnt_row increments.
  - At the last pixel of the frame (cnt_row=IN_ROWS-1, cnt_col=IN_COLS-1, handshake) -> DONE.
  - DONE: ap_done pulses for one cycle, counters are 0, then -> IDLE with ap_idle=1.
- s_axis_tready = (state==RUN) && (buffer empty || (index==PIXELS_PER_BURST-1 && m_axis_tready)) && bursts_taken < IN_ROWS*BURSTS_PER_ROW.
  - This back-to-back reload gives 1 pixel/cycle sustained throughput with no bubble between bursts.
- Burst handshake: the burst is loaded into the buffer and index resets to 0. The first pixel appears on m_axis the following cycle, so latency from burst handshake to first pixel valid is 1 cycle.
- The block never accepts more than IN_ROWS*BURSTS_PER_ROW bursts per frame. Excess input stays stalled until the next frame.
- With m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, cnt_col and cnt_row hold stable.
- ap_start is ignored outside IDLE.
- ap_start held high continuously: a new frame starts in the cycle after DONE returns to IDLE.
- Counter widths are exactly $clog2 of the dimension. No arithmetic overflow is possible because wrap occurs at dimension-1.
- Input stall (s_axis_tvalid=0) with an empty buffer: m_axis_tvalid=0. Counters hold.

Decomposition:
- Shared package pipeline_pkg holds:
  - the Mono8 pixel typedef (logic [7:0]);
  - the ap-control state enum (IDLE, RUN, DONE);
  - the function burst_bytes(IN_W).
- One natural sub-module: raster_counter. It holds parameterized cnt_col/cnt_row with an advance input and last_pixel/wrap outputs, and is reusable by crop stages.
- The FSM and burst buffer stay in burst_sequentializer.

Test Plan:
- Bench configuration for all scenarios: IN_ROWS=4, IN_COLS=8, PIXELS_PER_BURST=4.
- Full-throughput frame: ap_start, then 8 bursts back-to-back with bytes 0x00..0x1F, m_axis_tready=1.
  - Required: pixels 0x00..0x1F on 32 consecutive cycles starting 1 cycle after the first burst handshake.
  - Required: (cnt_row,cnt_col) goes (0,0)..(3,7).
  - Required: ap_done pulses once, then ap_idle=1.
- Downstream backpressure: m_axis_tready toggles 1,0,0,1 repeatedly.
  - Required: no pixel lost or duplicated.
  - Required: data and counters stay stable while stalled.
  - Required: s_axis_tready=0 while the buffer still holds unsent pixels.
- Input gaps: s_axis_tvalid low for 3 cycles between bursts.
  - Required: m_axis_tvalid=0 during the gap.
  - Required: output sequence identical to the full-throughput case.
- Frame bound: 10 bursts offered in one frame.
  - Required: only 8 accepted.
  - Required: burst 9 is stalled, then accepted as the first burst of the next frame after ap_start.
- Reset mid-frame: reset=0 after 13 pixels.
  - Required: m_axis_tvalid=0, counters=0, ap_idle=1 immediately; no ap_done.
  - Required: a subsequent full frame is correct from pixel (0,0).
- Continuous ap_start: two frames back-to-back.
  - Required: ap_ready pulses twice and ap_done pulses twice.
  - Required: counters restart at (0,0) for the second frame.
